// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the CPU decode stage. Holds the NOP
//               opcode value and helpers that slice an instruction word laid
//               out as {opcode, src1_idx, src2_idx}, opcode in the MSBs.
//               The helpers take widths as arguments so one set of functions
//               serves every parametrisation. Callers size the results.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int OPC_NOP = 0;

    // Opcode field: the OPC_W bits sitting above the two index fields.
    function automatic logic [31:0] instr_opc(input logic [63:0] instr,
                                              input int opc_w,
                                              input int idx_w);
        return 32'((instr >> (2 * idx_w)) & ((64'd1 << opc_w) - 64'd1));
    endfunction

    // First source index; it also names the destination register.
    function automatic logic [31:0] instr_src1(input logic [63:0] instr,
                                               input int idx_w);
        return 32'((instr >> idx_w) & ((64'd1 << idx_w) - 64'd1));
    endfunction

    // Second source index, in the least significant bits.
    function automatic logic [31:0] instr_src2(input logic [63:0] instr,
                                               input int idx_w);
        return 32'(instr & ((64'd1 << idx_w) - 64'd1));
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_operand_sel.sv
`default_nettype none
// ============================================================================
// Module      : cpu_operand_sel
// Description : Reads one source operand from the flattened register file,
//               replacing it with the write-back value when a write-back to
//               the same register is in flight this cycle.
// Ports       : regs_i     - register file, reg k at [k*DATA_W +: DATA_W]
//               src_idx_i  - register to read
//               wb_valid_i - write-back active this cycle
//               wb_idx_i   - write-back destination
//               wb_data_i  - write-back value
//               operand_o  - selected operand (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_operand_sel #(
    parameter  int DATA_W = 8,
    parameter  int NREGS  = 4,
    localparam int IDX_W  = $clog2(NREGS)
) (
    input  logic [NREGS*DATA_W-1:0] regs_i,
    input  logic [IDX_W-1:0]        src_idx_i,
    input  logic                    wb_valid_i,
    input  logic [IDX_W-1:0]        wb_idx_i,
    input  logic [DATA_W-1:0]       wb_data_i,
    output logic [DATA_W-1:0]       operand_o
);

    logic w_fwd;

    assign w_fwd = wb_valid_i && (wb_idx_i == src_idx_i);

    always_comb begin
        operand_o = regs_i[src_idx_i * DATA_W +: DATA_W];
        if (w_fwd) begin
            operand_o = wb_data_i;
        end
    end

endmodule : cpu_operand_sel
`default_nettype wire

// File: rtl/cpu_dc_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cpu_dc_pipe
// Description : Pipelined decode stage. Splits an instruction into opcode and
//               register indices, reads both operands with write-back
//               forwarding, and holds the result in a one-entry output
//               register under a valid/ready handshake. A per-register
//               scoreboard stalls instructions touching a register with an
//               outstanding write.
// Ports       : clk, rst_n          - clock, async active-low reset
//               flush               - drop output entry, clear scoreboard
//               in_valid/in_ready   - instruction handshake
//               instr               - {opcode, src1_idx, src2_idx}
//               regs                - flattened register file
//               wb_valid/idx/data   - write-back port
//               out_valid/out_ready - output handshake
//               opcode, in1_val, in2_val, dst_idx - registered payload
//               busy                - scoreboard, bit k = reg k pending
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_dc_pipe
    import cpu_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int NREGS   = 4,
    parameter  int OPC_W   = 4,
    localparam int IDX_W   = $clog2(NREGS),
    localparam int INSTR_W = OPC_W + 2 * IDX_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INSTR_W-1:0]      instr,
    input  logic [NREGS*DATA_W-1:0] regs,
    input  logic                    wb_valid,
    input  logic [IDX_W-1:0]        wb_idx,
    input  logic [DATA_W-1:0]       wb_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OPC_W-1:0]        opcode,
    output logic [DATA_W-1:0]       in1_val,
    output logic [DATA_W-1:0]       in2_val,
    output logic [IDX_W-1:0]        dst_idx,
    output logic [NREGS-1:0]        busy
);

    logic [OPC_W-1:0]  w_opc;
    logic [IDX_W-1:0]  w_src1;
    logic [IDX_W-1:0]  w_src2;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;
    logic [NREGS-1:0]  w_wb_mask;
    logic [NREGS-1:0]  w_eff;
    logic [NREGS-1:0]  w_set_mask;
    logic              w_hazard;
    logic              w_accept;
    logic              w_is_nop;

    logic              out_valid_q, out_valid_d;
    logic [OPC_W-1:0]  opcode_q,    opcode_d;
    logic [DATA_W-1:0] in1_q,       in1_d;
    logic [DATA_W-1:0] in2_q,       in2_d;
    logic [IDX_W-1:0]  dst_q,       dst_d;
    logic [NREGS-1:0]  busy_q,      busy_d;

    assign w_opc    = OPC_W'(instr_opc(64'(instr), OPC_W, IDX_W));
    assign w_src1   = IDX_W'(instr_src1(64'(instr), IDX_W));
    assign w_src2   = IDX_W'(instr_src2(64'(instr), IDX_W));
    assign w_is_nop = (w_opc == OPC_W'(OPC_NOP));

    cpu_operand_sel #(.DATA_W(DATA_W), .NREGS(NREGS)) u_sel1 (
        .regs_i     (regs),
        .src_idx_i  (w_src1),
        .wb_valid_i (wb_valid),
        .wb_idx_i   (wb_idx),
        .wb_data_i  (wb_data),
        .operand_o  (w_op1)
    );

    cpu_operand_sel #(.DATA_W(DATA_W), .NREGS(NREGS)) u_sel2 (
        .regs_i     (regs),
        .src_idx_i  (w_src2),
        .wb_valid_i (wb_valid),
        .wb_idx_i   (wb_idx),
        .wb_data_i  (wb_data),
        .operand_o  (w_op2)
    );

    // A write-back landing this cycle already resolves its register, so the
    // waiting instruction may issue now and pick up the forwarded value.
    assign w_wb_mask = wb_valid ? (NREGS'(1) << wb_idx) : '0;
    assign w_eff     = busy_q & ~w_wb_mask;
    // dst is src1, so the WAW check is already covered by the src1 term.
    assign w_hazard  = w_eff[w_src1] | w_eff[w_src2];

    assign in_ready  = rst_n && !flush && !w_hazard && (!out_valid_q || out_ready);
    assign w_accept  = in_valid && in_ready;

    assign w_set_mask = (w_accept && !w_is_nop) ? (NREGS'(1) << w_src1) : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        opcode_d    = opcode_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        dst_d       = dst_q;
        busy_d      = busy_q;
        if (flush) begin
            // in_ready is low under flush, so no accept can collide here.
            out_valid_d = 1'b0;
            busy_d      = '0;
        end else begin
            // Set is OR-ed in after the clear so a new claim beats a wb.
            busy_d = (busy_q & ~w_wb_mask) | w_set_mask;
            if (w_accept) begin
                out_valid_d = 1'b1;
                opcode_d    = w_opc;
                in1_d       = w_op1;
                in2_d       = w_op2;
                dst_d       = w_src1;
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            dst_q       <= '0;
            busy_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            opcode_q    <= opcode_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            dst_q       <= dst_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign opcode    = opcode_q;
    assign in1_val   = in1_q;
    assign in2_val   = in2_q;
    assign dst_idx   = dst_q;
    assign busy      = busy_q;

endmodule : cpu_dc_pipe
`default_nettype wire

// File: tb/tb_cpu_dc_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_dc_pipe
// Description : Self-checking bench for cpu_dc_pipe. A default-size instance
//               (8-bit data, 4 registers) runs directed scenarios and random
//               traffic against a behavioural model; a second instance
//               (16-bit data, 8 registers) checks wide indexing and dual
//               forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_dc_pipe;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int XW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic            wb_valid = 1'b0;
    logic [XW-1:0]   instr = '0;
    logic [NR*DW-1:0] regs = '0;
    logic [1:0]      wb_idx = '0;
    logic [DW-1:0]   wb_data = '0;
    logic            in_ready;
    logic            out_valid;
    logic [3:0]      opcode;
    logic [DW-1:0]   in1_val;
    logic [DW-1:0]   in2_val;
    logic [1:0]      dst_idx;
    logic [NR-1:0]   busy;

    // Wide instance signals
    logic            p_flush = 1'b0;
    logic            p_in_valid = 1'b0;
    logic            p_out_ready = 1'b1;
    logic            p_wb_valid = 1'b0;
    logic [9:0]      p_instr = '0;
    logic [127:0]    p_regs = '0;
    logic [2:0]      p_wb_idx = '0;
    logic [15:0]     p_wb_data = '0;
    logic            p_in_ready;
    logic            p_out_valid;
    logic [3:0]      p_opcode;
    logic [15:0]     p_in1_val;
    logic [15:0]     p_in2_val;
    logic [2:0]      p_dst_idx;
    logic [7:0]      p_busy;

    always #5 clk = ~clk;

    cpu_dc_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .regs(regs),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
        .in1_val(in1_val), .in2_val(in2_val), .dst_idx(dst_idx), .busy(busy)
    );

    cpu_dc_pipe #(.DATA_W(16), .NREGS(8), .OPC_W(4)) u_dut_wide (
        .clk(clk), .rst_n(rst_n), .flush(p_flush),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .instr(p_instr), .regs(p_regs),
        .wb_valid(p_wb_valid), .wb_idx(p_wb_idx), .wb_data(p_wb_data),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .opcode(p_opcode),
        .in1_val(p_in1_val), .in2_val(p_in2_val), .dst_idx(p_dst_idx), .busy(p_busy)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: a set of pending registers and one output slot.
    bit m_busy[NR];
    bit m_vld;
    int m_opc, m_in1, m_in2, m_dst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] m_busy_vec();
        logic [NR-1:0] v;
        for (int k = 0; k < NR; k++) v[k] = m_busy[k];
        return v;
    endfunction

    function automatic bit pending(input int s);
        return m_busy[s] && !(wb_valid && int'(wb_idx) == s);
    endfunction

    function automatic int read_op(input int s);
        if (wb_valid && int'(wb_idx) == s) return int'(wb_data);
        return int'(regs[s*DW +: DW]);
    endfunction

    task automatic m_reset();
        for (int k = 0; k < NR; k++) m_busy[k] = 1'b0;
        m_vld = 1'b0; m_opc = 0; m_in1 = 0; m_in2 = 0; m_dst = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_vld));
        chk({tag, ".busy"},      64'(busy),      64'(m_busy_vec()));
        chk({tag, ".opcode"},    64'(opcode),    64'(m_opc));
        chk({tag, ".in1"},       64'(in1_val),   64'(m_in1));
        chk({tag, ".in2"},       64'(in2_val),   64'(m_in2));
        chk({tag, ".dst"},       64'(dst_idx),   64'(m_dst));
    endtask

    // One clock: inputs already driven; check in_ready, predict, clock, compare.
    task automatic step(input string tag);
        int  iv, opc, s1, s2;
        bit  rdy, acc, nv;
        bit  nb[NR];
        #1;
        iv  = int'(instr);
        opc = iv / 16;
        s1  = (iv / 4) % 4;
        s2  = iv % 4;
        rdy = rst_n && !flush && !(pending(s1) || pending(s2)) && (!m_vld || out_ready);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
        acc = in_valid && rdy;
        nb  = m_busy;
        nv  = m_vld;
        if (flush) begin
            nv = 1'b0;
            for (int k = 0; k < NR; k++) nb[k] = 1'b0;
        end else begin
            if (wb_valid) nb[wb_idx] = 1'b0;
            if (m_vld && out_ready) nv = 1'b0;
            if (acc) begin
                nv    = 1'b1;
                m_opc = opc;
                m_in1 = read_op(s1);
                m_in2 = read_op(s2);
                m_dst = s1;
                if (opc != 0) nb[s1] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        m_busy = nb;
        m_vld  = nv;
        check_outputs(tag);
    endtask

    logic [15:0] p_r[8];

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset.in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic decode
        regs = {8'd7, 8'd3, 8'd9, 8'd5};
        instr = 8'h16; in_valid = 1'b1; out_ready = 1'b0;
        step("basic");
        chk("basic.lit_vld",  64'(out_valid), 64'd1);
        chk("basic.lit_opc",  64'(opcode),    64'd1);
        chk("basic.lit_in1",  64'(in1_val),   64'd9);
        chk("basic.lit_in2",  64'(in2_val),   64'd3);
        chk("basic.lit_dst",  64'(dst_idx),   64'd1);
        chk("basic.lit_busy", 64'(busy),      64'b0010);

        // RAW stall, then release by write-back with forwarding
        instr = 8'h24; out_ready = 1'b1;
        step("raw_wait");
        chk("raw.lit_stall", 64'(in_ready), 64'd0);
        wb_valid = 1'b1; wb_idx = 2'd1; wb_data = 8'd42;
        step("raw_wb");
        chk("raw.lit_in1",  64'(in1_val), 64'd42);
        chk("raw.lit_opc",  64'(opcode),  64'd2);
        chk("raw.lit_busy", 64'(busy),    64'b0010);
        wb_valid = 1'b0;

        // Backpressure
        instr = 8'h3F; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("bp_hold");
            chk("bp.lit_in1",   64'(in1_val),  64'd42);
            chk("bp.lit_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        step("bp_release");
        chk("bp.lit_opc",  64'(opcode),  64'd3);
        chk("bp.lit_dst",  64'(dst_idx), 64'd3);
        chk("bp.lit_busy", 64'(busy),    64'b1010);

        // Flush
        out_ready = 1'b0; flush = 1'b1;
        step("flush");
        chk("flush.lit_vld",  64'(out_valid), 64'd0);
        chk("flush.lit_busy", 64'(busy),      64'd0);
        flush = 1'b0; out_ready = 1'b1;

        // NOP leaves the scoreboard alone; follower issues without stall
        instr = 8'h05;
        step("nop");
        chk("nop.lit_busy", 64'(busy),    64'd0);
        chk("nop.lit_in1",  64'(in1_val), 64'd9);
        instr = 8'h15;
        step("after_nop");
        chk("after_nop.lit_opc",  64'(opcode), 64'd1);
        chk("after_nop.lit_busy", 64'(busy),   64'b0010);

        // Async reset mid-stall
        instr = 8'h24;
        step("pre_reset");
        rst_n = 1'b0;
        #1;
        m_reset();
        check_outputs("async_reset");
        chk("async_reset.in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_reset");

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = ($urandom_range(0, 1) != 0);
            wb_idx    = 2'($urandom_range(0, 3));
            wb_data   = 8'($urandom);
            flush     = ($urandom_range(0, 31) == 0);
            regs      = 32'($urandom);
            instr     = 8'($urandom);
            if ($urandom_range(0, 3) == 0) instr[7:4] = 4'h0;
            step("rand");
        end
        in_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;

        // Wide instance: every index read, then dual forwarding
        for (int k = 0; k < 8; k++) begin
            p_r[k] = 16'($urandom);
            p_regs[k*16 +: 16] = p_r[k];
        end
        p_in_valid = 1'b1;
        for (int s = 0; s < 8; s++) begin
            p_instr = {4'h0, 3'(s), 3'(7 - s)};
            @(posedge clk);
            #1;
            chk("wide.in1", 64'(p_in1_val), 64'(p_r[s]));
            chk("wide.in2", 64'(p_in2_val), 64'(p_r[7 - s]));
        end
        p_instr = {4'h5, 3'd6, 3'd6};
        p_wb_valid = 1'b1; p_wb_idx = 3'd6; p_wb_data = 16'hBEEF;
        @(posedge clk);
        #1;
        chk("wide.fwd_in1", 64'(p_in1_val), 64'hBEEF);
        chk("wide.fwd_in2", 64'(p_in2_val), 64'hBEEF);
        chk("wide.busy",    64'(p_busy),    64'h40);
        chk("wide.dst",     64'(p_dst_idx), 64'd6);
        p_in_valid = 1'b0; p_wb_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cpu_dc_pipe
`default_nettype wire
